// File: rtl/apb_reg_completer_pkg.sv
// Shared types and constants for the APB register completer.
//   state_e   : transfer FSM states (IDLE, WAIT, DONE)
//   CNT_W     : width of the wait-state counter
//   RESET_VAL : fill bit used for register and output reset values
package apb_completer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int   CNT_W     = 4;
    localparam logic RESET_VAL = 1'b0;

endpackage

// File: rtl/apb_reg_completer_if.sv
// APB bus bundle for one completer select line.
//   master : drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, receives PRDATA/PREADY/PSLVERR
//   slave  : the mirror image, used by apb_reg_completer
interface apb_reg_completer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_reg_completer_addr_decode.sv
// Combinational address decoder for the APB register completer.
//   paddr  : byte address presented on the bus
//   pwrite : transfer direction (1 = write)
//   idx    : register slot addressed by paddr
//   err    : misaligned, outside the register window, or a write to a read-only slot
module apb_addr_decode
    import apb_completer_pkg::*;
#(
    parameter int                  ADDR_W    = 16,
    parameter int                  NUM_REGS  = 8,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = 16'h0000,
    parameter logic [NUM_REGS-1:0] RO_MASK   = 8'h00
) (
    input  logic [ADDR_W-1:0]           paddr,
    input  logic                        pwrite,
    output logic [$clog2(NUM_REGS)-1:0] idx,
    output logic                        err
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [ADDR_W-1:0] offset_s;
    logic              out_of_range_s;
    logic              ro_hit_s;

    // Offset into the window, slot index and error classification.
    // BASE_ADDR is aligned, so offset bit 0 equals paddr bit 0; any set bit
    // above the slot field means the offset is at or past 2*NUM_REGS (addresses
    // below the base wrap to large offsets and are caught the same way).
    always_comb begin
        offset_s       = paddr - BASE_ADDR;
        idx            = offset_s[IDX_W:1];
        out_of_range_s = |offset_s[ADDR_W-1:IDX_W+1];
        ro_hit_s       = pwrite & RO_MASK[idx];
        err            = offset_s[0] | out_of_range_s | ro_hit_s;
    end

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer with a NUM_REGS x DATA_W register file and fixed wait states.
//   PCLK, PRESET : bus clock, synchronous active-high reset
//   apb          : APB slave modport (PSEL/PENABLE/PWRITE/PADDR/PWDATA in,
//                  PRDATA/PREADY/PSLVERR out, all outputs registered)
//   reg_out      : register contents, slot i at [i*DATA_W +: DATA_W]
//   ro_in        : status words returned by read-only slots
//   wr_strobe    : one-cycle pulse per slot, the cycle after a write commits
module apb_reg_completer
    import apb_completer_pkg::*;
#(
    parameter int                  ADDR_W      = 16,
    parameter int                  DATA_W      = 16,
    parameter int                  NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0]   BASE_ADDR   = 16'h0000,
    parameter int                  WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = 8'h00
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    apb_reg_completer_if.slave           apb,
    output logic [NUM_REGS*DATA_W-1:0]   reg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
    output logic [NUM_REGS-1:0]          wr_strobe
);

    localparam int               IDX_W   = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] WS_C    = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e              state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r, cnt_next_s;
    logic                capture_s, commit_s;

    logic [IDX_W-1:0]    dec_idx_s, idx_r, idx_d_s;
    logic                dec_err_s, err_r, err_d_s;
    logic                we_r, we_d_s;
    logic [DATA_W-1:0]   wdata_r;

    logic [DATA_W-1:0]   regs_r [NUM_REGS];

    logic                ready_next_s, pslverr_next_s;
    logic [DATA_W-1:0]   prdata_next_s;
    logic [NUM_REGS-1:0] strobe_next_s;
    logic                pready_r, pslverr_r;
    logic [DATA_W-1:0]   prdata_r;
    logic [NUM_REGS-1:0] wr_strobe_r;

    apb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .RO_MASK   (RO_MASK)
    ) u_decode (
        .paddr  (apb.PADDR),
        .pwrite (apb.PWRITE),
        .idx    (dec_idx_s),
        .err    (dec_err_s)
    );

    // Transfer FSM: next state, wait counter, capture and commit decisions.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        capture_s    = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    capture_s = 1'b1;
                    if (WS_C == {CNT_W{1'b0}}) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = WS_C;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                // Losing PSEL mid-wait aborts the transfer without a response.
                if (!apb.PSEL) begin
                    state_next_s = IDLE;
                end else if (cnt_r == CNT_ONE) begin
                    state_next_s = DONE;
                end else begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end
            end
            DONE: begin
                state_next_s = IDLE;
                commit_s     = apb.PSEL & we_r & ~err_r;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Next values of the registered bus outputs and write strobes. When the
    // FSM goes straight from IDLE to DONE the capture registers are not yet
    // loaded, so the decoder result is used directly in that case.
    always_comb begin
        if (capture_s) begin
            idx_d_s = dec_idx_s;
            we_d_s  = apb.PWRITE;
            err_d_s = dec_err_s;
        end else begin
            idx_d_s = idx_r;
            we_d_s  = we_r;
            err_d_s = err_r;
        end
        ready_next_s   = (state_next_s == DONE);
        pslverr_next_s = ready_next_s & err_d_s;
        if (ready_next_s && !we_d_s && !err_d_s) begin
            if (RO_MASK[idx_d_s]) begin
                prdata_next_s = ro_in[idx_d_s*DATA_W +: DATA_W];
            end else begin
                prdata_next_s = regs_r[idx_d_s];
            end
        end else begin
            prdata_next_s = {DATA_W{1'b0}};
        end
        strobe_next_s = {NUM_REGS{1'b0}};
        if (commit_s) begin
            strobe_next_s[idx_r] = 1'b1;
        end else begin
            strobe_next_s = {NUM_REGS{1'b0}};
        end
    end

    // FSM state, wait counter and SETUP-phase capture of address/direction/data.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            wdata_r <= {DATA_W{RESET_VAL}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (capture_s) begin
                idx_r   <= dec_idx_s;
                we_r    <= apb.PWRITE;
                err_r   <= dec_err_s;
                wdata_r <= apb.PWDATA;
            end
        end
    end

    // Registered bus response and write strobes.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            pready_r    <= 1'b0;
            pslverr_r   <= 1'b0;
            prdata_r    <= {DATA_W{RESET_VAL}};
            wr_strobe_r <= {NUM_REGS{1'b0}};
        end else begin
            pready_r    <= ready_next_s;
            pslverr_r   <= pslverr_next_s;
            prdata_r    <= prdata_next_s;
            wr_strobe_r <= strobe_next_s;
        end
    end

    // Register file; a write lands on the edge that ends DONE.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{RESET_VAL}};
            end
        end else if (commit_s) begin
            regs_r[idx_r] <= wdata_r;
        end
    end

    // Flatten the register file onto reg_out.
    always_comb begin
        reg_out = {(NUM_REGS*DATA_W){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_out[i*DATA_W +: DATA_W] = regs_r[i];
        end
    end

    assign apb.PREADY  = pready_r;
    assign apb.PSLVERR = pslverr_r;
    assign apb.PRDATA  = prdata_r;
    assign wr_strobe   = wr_strobe_r;

endmodule
